// File: rtl/counter_pkg.sv
// Shared types and per-nibble ripple step helpers for the up/down button counter.
// Digit vectors are sized for the widest build; callers pass the live digit count.
package counter_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  typedef logic [3:0] digit_t;
  typedef digit_t [MAX_DIGITS-1:0] digit_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } db_state_t;

  typedef struct packed {
    digit_vec_t val;
    logic       co;
  } step_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Carry/borrow ripples from digit 0; co is set only when every live digit rolled over.
  function automatic step_t ripple_step(input digit_vec_t d, input int unsigned n,
                                        input logic up, input digit_t top);
    step_t r;
    logic  c;
    r.val = d;
    c     = 1'b1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if ((i < n) && c) begin
        if (up) begin
          if (d[i] == top) begin
            r.val[i] = 4'd0;
          end else begin
            r.val[i] = d[i] + 4'd1;
            c        = 1'b0;
          end
        end else begin
          if (d[i] == 4'd0) begin
            r.val[i] = top;
          end else begin
            r.val[i] = d[i] - 4'd1;
            c        = 1'b0;
          end
        end
      end
    end
    r.co = c;
    return r;
  endfunction

  function automatic step_t dec_inc(input digit_vec_t d, input int unsigned n);
    return ripple_step(d, n, 1'b1, 4'd9);
  endfunction

  function automatic step_t dec_dec(input digit_vec_t d, input int unsigned n);
    return ripple_step(d, n, 1'b0, 4'd9);
  endfunction

  function automatic step_t hex_inc(input digit_vec_t d, input int unsigned n);
    return ripple_step(d, n, 1'b1, 4'hF);
  endfunction

  function automatic step_t hex_dec(input digit_vec_t d, input int unsigned n);
    return ripple_step(d, n, 1'b0, 4'hF);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button -> 2-flop synchroniser -> debounce FSM -> one-cycle press pulse.
// Hold-to-repeat exists only when UPDOWN_BTN_AUTO_REPEAT_EN is defined.
//
// state     | meaning
// IDLE      | released, waiting for sync high
// PRESS_CHK | sync high, counting DB_CYCLES of stability
// HELD      | press accepted; repeat timer runs here when enabled
// REL_CHK   | sync low, counting DB_CYCLES of stability before release
module button_conditioner
  import counter_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 1_000_000,
  parameter int unsigned RPT_DLY_CYCLES = 50_000_000,
  parameter int unsigned RPT_CYCLES     = 10_000_000
`ifdef UPDOWN_BTN_AUTO_REPEAT_EN
  ,
  parameter bit          REPEAT_EN      = 1'b1
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_MAX = max3(DB_CYCLES, RPT_DLY_CYCLES, RPT_CYCLES);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DB_TC = CW'(DB_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  logic meta_d, sync_d;

  db_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    meta_d = btn_raw;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef UPDOWN_BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RD_TC = CW'(RPT_DLY_CYCLES - 1);
  localparam logic [CW-1:0] RP_TC = CW'(RPT_CYCLES - 1);

  // Set once the first repeat has fired; selects the shorter interval afterwards.
  logic rpt_q, rpt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_q <= 1'b0;
    else     rpt_q <= rpt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
`ifdef UPDOWN_BTN_AUTO_REPEAT_EN
    rpt_d   = rpt_q && (state_q == HELD) && sync_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync_q) state_d = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          press   = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!sync_q) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end else begin
`ifdef UPDOWN_BTN_AUTO_REPEAT_EN
          if (REPEAT_EN) begin
            if (cnt_q == (rpt_q ? RP_TC : RD_TC)) begin
              press = 1'b1;
              cnt_d = '0;
              rpt_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      REL_CHK: begin
        if (sync_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/updown_button_counter.sv
// Multi-digit BCD/hex up/down counter fed by three debounced buttons (up, down, clear).
// Define UPDOWN_BTN_AUTO_REPEAT_EN to enable hold-to-repeat on up/down.
module updown_button_counter
  import counter_pkg::*;
#(
  parameter string       MODE           = "DEC",
  parameter int unsigned NUM_SEGMENTS   = 8,
  parameter int unsigned DB_CYCLES      = 1_000_000,
  parameter int unsigned RPT_DLY_CYCLES = 50_000_000,
  parameter int unsigned RPT_CYCLES     = 10_000_000,
  parameter int unsigned SATURATE       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_clr,
  output logic [NUM_SEGMENTS-1:0][3:0] encoded,
  output logic [NUM_SEGMENTS-1:0]      decimal,
  output logic                         limit
);

  localparam bit IS_DEC = (MODE == "DEC");

  logic press_up, press_down, press_clr;

  button_conditioner #(
    .DB_CYCLES      (DB_CYCLES),
    .RPT_DLY_CYCLES (RPT_DLY_CYCLES),
    .RPT_CYCLES     (RPT_CYCLES)
`ifdef UPDOWN_BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_EN      (1'b1)
`endif
  ) u_btn_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_up),
    .press   (press_up)
  );

  button_conditioner #(
    .DB_CYCLES      (DB_CYCLES),
    .RPT_DLY_CYCLES (RPT_DLY_CYCLES),
    .RPT_CYCLES     (RPT_CYCLES)
`ifdef UPDOWN_BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_EN      (1'b1)
`endif
  ) u_btn_down (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_down),
    .press   (press_down)
  );

  // Clear never auto-repeats.
  button_conditioner #(
    .DB_CYCLES      (DB_CYCLES),
    .RPT_DLY_CYCLES (RPT_DLY_CYCLES),
    .RPT_CYCLES     (RPT_CYCLES)
`ifdef UPDOWN_BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_EN      (1'b0)
`endif
  ) u_btn_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clr),
    .press   (press_clr)
  );

  logic [NUM_SEGMENTS-1:0][3:0] cnt_q, cnt_d;
  logic                         limit_q, limit_d;
  digit_vec_t                   cur;
  step_t                        up_s, dn_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      limit_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  always_comb begin
    cur                     = '0;
    cur[NUM_SEGMENTS-1:0]   = cnt_q;
    up_s    = IS_DEC ? dec_inc(cur, NUM_SEGMENTS) : hex_inc(cur, NUM_SEGMENTS);
    dn_s    = IS_DEC ? dec_dec(cur, NUM_SEGMENTS) : hex_dec(cur, NUM_SEGMENTS);
    cnt_d   = cnt_q;
    limit_d = 1'b0;
    if (press_clr) begin
      cnt_d = '0;
    end else if (press_up && !press_down) begin
      limit_d = up_s.co;
      if (!(up_s.co && (SATURATE != 0))) cnt_d = up_s.val[NUM_SEGMENTS-1:0];
    end else if (press_down && !press_up) begin
      limit_d = dn_s.co;
      if (!(dn_s.co && (SATURATE != 0))) cnt_d = dn_s.val[NUM_SEGMENTS-1:0];
    end
  end

  assign encoded = cnt_q;
  assign decimal = '1;
  assign limit   = limit_q;

endmodule
